// File: rtl/sync_fifo_if.sv
// Handshake bundles for sync_fifo: user-side fifo_if and
// external dual-port RAM dp_ram_if.
interface fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;

  modport fifo (
    input  wr_en, data_in, rd_en,
    output full, data_out, empty
  );
  modport user (
    output wr_en, data_in, rd_en,
    input  full, data_out, empty
  );
endinterface

interface dp_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 8
);
  localparam int AW = $clog2(RAM_DEPTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] data_out;

  modport sys (
    output wr_en, wr_addr, data_in,
    output rd_en, rd_addr,
    input  data_out
  );
  modport ram (
    input  wr_en, wr_addr, data_in,
    input  rd_en, rd_addr,
    output data_out
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO controller over an external dual-port RAM.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through mode.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic   clk,
  input logic   rst,
  fifo_if.fifo  fifo,
  dp_ram_if.sys ram
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ptr_empty;
  logic        ptr_full;
  logic        wr_acc;
  logic        rd_acc;

  assign ptr_empty = wr_ptr_q == rd_ptr_q;
  assign ptr_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Enables are masked during reset so nothing leaks into the RAM.
  assign wr_acc = fifo.wr_en && !ptr_full && !rst;

`ifdef SYNC_FIFO_FWFT_EN
  logic out_valid_q, out_valid_d;

  assign rd_acc = !ptr_empty && !rst &&
                  (!out_valid_q || fifo.rd_en);

  always_comb begin
    out_valid_d = out_valid_q;
    if (rd_acc)
      out_valid_d = 1'b1;
    else if (fifo.rd_en)
      out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      out_valid_q <= 1'b0;
    else
      out_valid_q <= out_valid_d;
  end

  assign fifo.empty = !out_valid_q;
`else
  assign rd_acc     = fifo.rd_en && !ptr_empty && !rst;
  assign fifo.empty = ptr_empty;
`endif

  assign fifo.full = ptr_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc)
      rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign ram.wr_en    = wr_acc;
  assign ram.wr_addr  = wr_ptr_q[AW-1:0];
  assign ram.data_in  = fifo.data_in;
  assign ram.rd_en    = rd_acc;
  assign ram.rd_addr  = rd_ptr_q[AW-1:0];
  assign fifo.data_out = ram.data_out;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a behavioural RAM.
// Checks standard mode, or FWFT mode when built with the macro.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fifo_if   #(.DATA_WIDTH(8)) fifo_bus ();
  dp_ram_if #(.DATA_WIDTH(8), .RAM_DEPTH(8)) ram_bus ();

  sync_fifo #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (fifo_bus),
    .ram  (ram_bus)
  );

  logic [7:0] mem [8];

  always @(posedge clk) begin
    if (ram_bus.wr_en)
      mem[ram_bus.wr_addr] <= ram_bus.data_in;
    if (ram_bus.rd_en)
      ram_bus.data_out <= mem[ram_bus.rd_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_bus.wr_en = 1'b0;
    fifo_bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_bus.wr_en   = 1'b1;
    fifo_bus.data_in = d;
    tick();
    fifo_bus.wr_en = 1'b0;
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] e;
    fifo_bus.data_in = '0;
    do_reset();

    check("rst_empty", fifo_bus.empty, 1);
    check("rst_full", fifo_bus.full, 0);
    check("rst_ram_wen", ram_bus.wr_en, 0);
    check("rst_ram_ren", ram_bus.rd_en, 0);
    check("rst_waddr", ram_bus.wr_addr, 0);
    check("rst_raddr", ram_bus.rd_addr, 0);

`ifdef SYNC_FIFO_FWFT_EN
    push(8'h55);
    check("fw_empty_c1", fifo_bus.empty, 1);
    tick();
    check("fw_empty_c2", fifo_bus.empty, 0);
    check("fw_data_c2", fifo_bus.data_out, 8'h55);
    fifo_bus.rd_en = 1'b1;
    tick();
    fifo_bus.rd_en = 1'b0;
    check("fw_pop_empty", fifo_bus.empty, 1);
    tick();

    for (int i = 0; i < 9; i++) begin
      fifo_bus.wr_en   = 1'b1;
      fifo_bus.data_in = 8'(8'h80 + i);
      tick();
    end
    fifo_bus.wr_en = 1'b0;
    check("fw_full9", fifo_bus.full, 1);
    fifo_bus.wr_en   = 1'b1;
    fifo_bus.data_in = 8'hFF;
    #1;
    check("fw_drop_wen", ram_bus.wr_en, 0);
    fifo_bus.wr_en = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("fw_empty_drain", fifo_bus.empty, 0);
      check("fw_data_drain", fifo_bus.data_out,
            32'(8'h80 + i));
      fifo_bus.rd_en = 1'b1;
      tick();
    end
    fifo_bus.rd_en = 1'b0;
    check("fw_drained", fifo_bus.empty, 1);
    check("fw_not_full", fifo_bus.full, 0);
`else
    fifo_bus.rd_en = 1'b1;
    #1;
    check("idle_rd_ignored", ram_bus.rd_en, 0);
    tick();
    fifo_bus.rd_en = 1'b0;

    for (int i = 0; i < 8; i++) begin
      fifo_bus.wr_en   = 1'b1;
      fifo_bus.data_in = 8'(8'h10 + i);
      #1;
      check("fill_wen", ram_bus.wr_en, 1);
      check("fill_full_pre", fifo_bus.full, 0);
      tick();
    end
    check("fill_full", fifo_bus.full, 1);
    fifo_bus.data_in = 8'hFF;
    #1;
    check("ovf_wen", ram_bus.wr_en, 0);
    tick();
    fifo_bus.wr_en = 1'b0;
    check("ovf_still_full", fifo_bus.full, 1);
    fifo_bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain_data", fifo_bus.data_out,
            32'(8'h10 + i));
    end
    fifo_bus.rd_en = 1'b0;
    check("drain_empty", fifo_bus.empty, 1);
    tick();
    check("data_hold", fifo_bus.data_out, 8'h17);

    for (int i = 0; i < 5; i++) push(8'(i));
    fifo_bus.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    fifo_bus.rd_en = 1'b0;
    check("wrap_empty", fifo_bus.empty, 1);
    for (int i = 0; i < 8; i++) begin
      fifo_bus.wr_en   = 1'b1;
      fifo_bus.data_in = 8'(8'hA0 + i);
      #1;
      check("wrap_addr", ram_bus.wr_addr, (5 + i) % 8);
      tick();
    end
    fifo_bus.wr_en = 1'b0;
    check("wrap_full", fifo_bus.full, 1);
    fifo_bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("wrap_data", fifo_bus.data_out,
            32'(8'hA0 + i));
    end
    fifo_bus.rd_en = 1'b0;
    check("wrap_empty2", fifo_bus.empty, 1);

    for (int i = 0; i < 3; i++) begin
      push(8'(8'h30 + i));
      q.push_back(8'(8'h30 + i));
    end
    fifo_bus.wr_en = 1'b1;
    fifo_bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fifo_bus.data_in = 8'(8'h40 + i);
      q.push_back(8'(8'h40 + i));
      tick();
      e = q.pop_front();
      check("rw_data", fifo_bus.data_out, e);
      check("rw_empty", fifo_bus.empty, 0);
      check("rw_full", fifo_bus.full, 0);
    end
    fifo_bus.wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = q.pop_front();
      check("rw_tail", fifo_bus.data_out, e);
    end
    fifo_bus.rd_en = 1'b0;
    check("rw_empty_end", fifo_bus.empty, 1);

    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    check("rwf_full", fifo_bus.full, 1);
    fifo_bus.wr_en   = 1'b1;
    fifo_bus.data_in = 8'hEE;
    fifo_bus.rd_en   = 1'b1;
    #1;
    check("rwf_wen", ram_bus.wr_en, 0);
    check("rwf_ren", ram_bus.rd_en, 1);
    tick();
    fifo_bus.wr_en = 1'b0;
    check("rwf_full_drop", fifo_bus.full, 0);
    check("rwf_data", fifo_bus.data_out, 8'h50);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("rwf_drain", fifo_bus.data_out,
            32'(8'h50 + i));
    end
    fifo_bus.rd_en = 1'b0;
    check("rwf_empty", fifo_bus.empty, 1);

    fifo_bus.wr_en   = 1'b1;
    fifo_bus.data_in = 8'h66;
    fifo_bus.rd_en   = 1'b1;
    #1;
    check("rwe_wen", ram_bus.wr_en, 1);
    check("rwe_ren", ram_bus.rd_en, 0);
    tick();
    idle();
    check("rwe_empty", fifo_bus.empty, 0);
    fifo_bus.rd_en = 1'b1;
    tick();
    fifo_bus.rd_en = 1'b0;
    check("rwe_data", fifo_bus.data_out, 8'h66);

    for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
    check("pre_rst_empty", fifo_bus.empty, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_empty", fifo_bus.empty, 1);
    check("mid_rst_full", fifo_bus.full, 0);
    push(8'h88);
    fifo_bus.rd_en = 1'b1;
    tick();
    fifo_bus.rd_en = 1'b0;
    check("post_rst_data", fifo_bus.data_out, 8'h88);
    check("post_rst_empty", fifo_bus.empty, 1);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
